lsu_mem_ctrl: RTL and testbench
===============================

// Module: lsu_mem_ctrl
// PURPOSE
// Load/store unit between the multicycle control unit and the 64-bit data memory.
// On a START pulse it captures the ALU-computed address, store data and FUNCT3.
// It then runs a REQ/ACK transaction with the memory and handles byte lanes
// (byte enables on stores, sign/zero extension on loads).
// The loaded value is held in an MDR-style register for the write-back state.
// PARAMETERS
// DATA_W   64  data path and address width (fixed 64; lane logic assumes 8 byte lanes)
// TIMEOUT  16  max cycles in REQ without MEM_ACK before ERR
// PORTS
// CLK         in   1   clock, rising edge
// RESET_N     in   1   asynchronous, active-low reset
// START       in   1   1-cycle pulse from control unit: begin access
// WRITE       in   1   1 = store, 0 = load
// FUNCT3      in   3   000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu, 111 illegal
// ADDR        in   64  byte address (ALU result)
// STORE_DATA  in   64  store operand (register B), data in low bits
// BUSY        out  1   high from the cycle after START until the DONE cycle inclusive
// DONE        out  1   1-cycle pulse: access finished (success or error)
// ERR         out  1   valid with DONE: misaligned, illegal FUNCT3 or timeout
// LOAD_DATA   out  64  registered, extended load result
// MEM_REQ     out  1   memory request, held until ACK
// MEM_WE      out  1   1 = write
// MEM_ADDR    out  64  doubleword-aligned address, {ADDR[63:3],3'b000}
// MEM_BE      out  8   byte enables
// MEM_WDATA   out  64  lane-shifted store data
// MEM_RDATA   in   64  read data, valid in the ACK cycle
// MEM_ACK     in   1   memory completes the request in this cycle
// BEHAVIOUR
// - Reset (RESET_N=0, async): state IDLE; all outputs 0, LOAD_DATA=0, timeout counter 0.
//   Asserting RESET_N=0 mid-transaction drops MEM_REQ immediately.
// - States:
//   - IDLE: START=1 captures WRITE/FUNCT3/ADDR/STORE_DATA.
//     - Next state is ERR_ST if the access is illegal: FUNCT3=111, store with FUNCT3>=100,
//       or misaligned (h: ADDR[0]!=0, w: ADDR[1:0]!=0, d: ADDR[2:0]!=0).
//     - Otherwise next state is REQ.
//   - REQ: MEM_REQ=1; MEM_WE/ADDR/BE/WDATA stable from captured values. Counter +1 per cycle.
//     - MEM_ACK=1 -> DONE_ST. On a load, LOAD_DATA is updated at this edge.
//     - Counter reaches TIMEOUT-1 with no ACK -> ERR_ST.
//   - DONE_ST: DONE=1, ERR=0 -> IDLE.
//   - ERR_ST: DONE=1, ERR=1 -> IDLE. No MEM_REQ is issued for an illegal access.
// - Timing: latency START(t0) -> MEM_REQ from t1 -> ACK sampled at tk -> DONE at tk+1.
//   Minimum is 3 cycles, with ACK at t1 and DONE at t2.
// - Lanes: off=ADDR[2:0].
//   - Size mask: b 0x01, h 0x03, w 0x0F, d 0xFF. MEM_BE = mask << off.
//   - MEM_WDATA = STORE_DATA << (8*off); bytes outside MEM_BE are 0.
//   - Loads: lane = MEM_RDATA >> (8*off), truncated to size, then sign-extended
//     (b,h,w) or zero-extended (bu,hu,wu); d is passed through.
//   - Loads drive MEM_BE with the size mask as well; MEM_WE=0.
// - LOAD_DATA changes only on a successful load. Stores, errors and timeouts leave it unchanged.
// - Ignored inputs: START while BUSY, and MEM_ACK outside REQ.
// - MEM_ACK in the same cycle the counter expires: ACK wins (success).
// - BUSY=0 in IDLE. A new START is accepted in the cycle after DONE.
// TESTING
// 1 Reset: RESET_N=0 during REQ -> MEM_REQ, BUSY, DONE, ERR, LOAD_DATA all 0 immediately;
//   IDLE after release.
// 2 LD ADDR=0x10, ACK 2 cycles after MEM_REQ with RDATA=0x1122334455667788
//   -> MEM_ADDR=0x10, MEM_BE=0xFF, LOAD_DATA=0x1122334455667788, DONE one cycle, ERR=0.
// 3 LB ADDR=0x13, RDATA byte3=0x80 -> LOAD_DATA=0xFFFFFFFFFFFFFF80, MEM_BE=0x08.
//   Same access as LBU -> LOAD_DATA=0x80.
// 4 SH ADDR=0x06, STORE_DATA=0xFFFF_ABCD, immediate ACK -> MEM_ADDR=0x0, MEM_WE=1,
//   MEM_BE=0xC0, MEM_WDATA=0xABCD000000000000, DONE at t2, LOAD_DATA unchanged.
// 5 LW ADDR=0x02 -> MEM_REQ never 1, DONE=ERR=1 at t1. SB with FUNCT3=100 -> same error.
// 6 SD, no ACK -> ERR with DONE after 16 REQ cycles, and extra START pulses during BUSY ignored.
//   Separately, ACK in the final timeout cycle -> success.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
// Load/store unit between the multicycle control unit and the 64-bit data
// memory. A START pulse in IDLE captures the access (direction, FUNCT3,
// address, store operand). The unit then runs one REQ/ACK transaction with
// memory and handles byte lanes: byte enables and lane-shifted data on stores,
// lane extraction plus sign/zero extension on loads. The extended load result
// is held in LOAD_DATA (MDR-style) for the control unit's write-back state.
//
// Ports
//   CLK         in   1   clock, rising edge
//   RESET_N     in   1   asynchronous, active-low reset
//   START       in   1   1-cycle pulse: begin an access (ignored while BUSY)
//   WRITE       in   1   1 = store, 0 = load
//   FUNCT3      in   3   000 b, 001 h, 010 w, 011 d, 100 bu, 101 hu, 110 wu
//   ADDR        in   64  byte address
//   STORE_DATA  in   64  store operand, data in low bits
//   BUSY        out  1   high from the cycle after START through the DONE cycle
//   DONE        out  1   1-cycle pulse: access finished
//   ERR         out  1   valid with DONE: misaligned, illegal FUNCT3 or timeout
//   LOAD_DATA   out  64  registered, extended load result
//   MEM_REQ     out  1   memory request, held until MEM_ACK
//   MEM_WE      out  1   1 = write
//   MEM_ADDR    out  64  doubleword-aligned address
//   MEM_BE      out  8   byte enables
//   MEM_WDATA   out  64  lane-shifted store data
//   MEM_RDATA   in   64  read data, valid in the MEM_ACK cycle
//   MEM_ACK     in   1   memory completes the request this cycle
//   DBG_STATE   out  2   current FSM state (0 IDLE, 1 REQ, 2 DONE, 3 ERR)
//
// Memory handshake: MEM_REQ is asserted with MEM_WE/MEM_ADDR/MEM_BE/MEM_WDATA
// stable for every cycle of the request; the transfer completes on the rising
// edge where MEM_REQ and MEM_ACK are both high. MEM_ACK while MEM_REQ is low
// has no effect. If no ACK arrives within TIMEOUT request cycles the access
// ends with ERR; an ACK in the last allowed cycle still counts as success.
//
// The lane logic assumes exactly 8 byte lanes, so DATA_W must stay 64.
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 16
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  input  logic              WRITE,
  input  logic [2:0]        FUNCT3,
  input  logic [DATA_W-1:0] ADDR,
  input  logic [DATA_W-1:0] STORE_DATA,
  output logic              BUSY,
  output logic              DONE,
  output logic              ERR,
  output logic [DATA_W-1:0] LOAD_DATA,
  output logic              MEM_REQ,
  output logic              MEM_WE,
  output logic [DATA_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_BE,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic [1:0]        DBG_STATE
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  state_t state, state_next;

  // Captured access
  logic              write_q;
  logic [2:0]        funct3_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] store_data_q;
  logic [DATA_W-1:0] load_q;
  logic [CNT_W-1:0]  cnt;

  logic              accept;
  logic              misaligned;
  logic              illegal;
  logic              timeout_hit;
  logic              ack_ok;

  logic [2:0]        off;
  logic [7:0]        size_mask;
  logic [7:0]        be_shift;
  logic [DATA_W-1:0] wdata_shift;
  logic [DATA_W-1:0] wdata_mask;
  logic [DATA_W-1:0] rdata_shift;
  logic [DATA_W-1:0] load_ext;

  assign accept = (state == S_IDLE) && START;

  // Legality is judged on the live inputs in the START cycle so the FSM can
  // go straight to the error state without ever raising MEM_REQ.
  always_comb begin
    misaligned = 1'b0;
    case (FUNCT3[1:0])
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = ADDR[0];
      2'b10:   misaligned = |ADDR[1:0];
      default: misaligned = |ADDR[2:0];
    endcase
  end

  assign illegal = (FUNCT3 == 3'b111) || (WRITE && FUNCT3[2]) || misaligned;

  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign ack_ok      = (state == S_REQ) && MEM_ACK;

  // State register
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (START) begin
          state_next = illegal ? S_ERR : S_REQ;
        end
      end
      S_REQ: begin
        // ACK takes priority over an expiring counter.
        if (MEM_ACK) begin
          state_next = S_DONE;
        end else if (timeout_hit) begin
          state_next = S_ERR;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Capture registers
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      write_q      <= 1'b0;
      funct3_q     <= 3'b000;
      addr_q       <= '0;
      store_data_q <= '0;
    end else if (accept) begin
      write_q      <= WRITE;
      funct3_q     <= FUNCT3;
      addr_q       <= ADDR;
      store_data_q <= STORE_DATA;
    end
  end

  // Request-cycle counter: 0 in the first REQ cycle, cleared outside REQ.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt <= '0;
    end else if (state == S_REQ) begin
      cnt <= cnt + 1'b1;
    end else begin
      cnt <= '0;
    end
  end

  // Lane logic
  assign off = addr_q[2:0];

  always_comb begin
    size_mask = 8'h01;
    case (funct3_q[1:0])
      2'b00:   size_mask = 8'h01;
      2'b01:   size_mask = 8'h03;
      2'b10:   size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  assign be_shift    = size_mask << off;
  assign wdata_shift = store_data_q << {off, 3'b000};
  assign rdata_shift = MEM_RDATA >> {off, 3'b000};

  // Expand byte enables to a bit mask so bytes outside MEM_BE read as zero.
  always_comb begin
    wdata_mask = '0;
    for (int i = 0; i < 8; i++) begin
      wdata_mask[8*i +: 8] = {8{be_shift[i]}};
    end
  end

  always_comb begin
    load_ext = rdata_shift;
    case (funct3_q)
      3'b000:  load_ext = {{56{rdata_shift[7]}},  rdata_shift[7:0]};
      3'b001:  load_ext = {{48{rdata_shift[15]}}, rdata_shift[15:0]};
      3'b010:  load_ext = {{32{rdata_shift[31]}}, rdata_shift[31:0]};
      3'b100:  load_ext = {56'd0, rdata_shift[7:0]};
      3'b101:  load_ext = {48'd0, rdata_shift[15:0]};
      3'b110:  load_ext = {32'd0, rdata_shift[31:0]};
      default: load_ext = rdata_shift;
    endcase
  end

  // MDR: only a completed load updates it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      load_q <= '0;
    end else if (ack_ok && !write_q) begin
      load_q <= load_ext;
    end
  end

  // Outputs: memory-side fields are driven only while requesting.
  always_comb begin
    BUSY      = (state != S_IDLE);
    DONE      = (state == S_DONE) || (state == S_ERR);
    ERR       = (state == S_ERR);
    MEM_REQ   = (state == S_REQ);
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_BE    = 8'h00;
    MEM_WDATA = '0;
    if (state == S_REQ) begin
      MEM_WE   = write_q;
      MEM_ADDR = {addr_q[DATA_W-1:3], 3'b000};
      MEM_BE   = be_shift;
      if (write_q) begin
        MEM_WDATA = wdata_shift & wdata_mask;
      end
    end
  end

  assign LOAD_DATA = load_q;
  assign DBG_STATE = state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_ctrl
// Bench for lsu_mem_ctrl. The driver issues accesses and pushes the expected
// outcome (computed from byte-level rules) into exp_q; a responder plays the
// memory with a per-access ACK delay and read data; a monitor compares every
// request cycle and every DONE against the head of exp_q.
// -----------------------------------------------------------------------------
module tb_lsu_mem_ctrl;

  localparam int TIMEOUT = 16;

  // ---------------- clock / reset ----------------
  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        START = 1'b0;
  logic        WRITE = 1'b0;
  logic [2:0]  FUNCT3 = 3'b000;
  logic [63:0] ADDR = '0;
  logic [63:0] STORE_DATA = '0;
  logic [63:0] MEM_RDATA = '0;
  logic        MEM_ACK = 1'b0;

  logic        BUSY, DONE, ERR, MEM_REQ, MEM_WE;
  logic [63:0] LOAD_DATA, MEM_ADDR, MEM_WDATA;
  logic [7:0]  MEM_BE;
  logic [1:0]  DBG_STATE;

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  lsu_mem_ctrl #(.DATA_W(64), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .START(START), .WRITE(WRITE),
    .FUNCT3(FUNCT3), .ADDR(ADDR), .STORE_DATA(STORE_DATA),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .LOAD_DATA(LOAD_DATA),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_BE(MEM_BE), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .MEM_ACK(MEM_ACK), .DBG_STATE(DBG_STATE)
  );

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic        legal;
    logic        is_err;
    logic        wr;
    logic [63:0] maddr;
    logic [7:0]  be;
    logic [63:0] wdata;
    logic [63:0] ld;
    int          start_cyc;
    int          done_cyc;
  } exp_t;

  typedef struct {
    int          delay;
    logic [63:0] rdata;
  } rsp_t;

  exp_t exp_q[$];
  rsp_t rsp_q[$];

  int          checks = 0;
  int          errors = 0;
  logic [63:0] ld_model = '0;
  bit          mon_en = 1'b0;
  bit          noise_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic exp_t model(input logic wr, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] sdata,
                                 input int delay, input logic [63:0] rdata,
                                 input logic [63:0] prev_ld);
    exp_t        e;
    int          size;
    int          off;
    logic [63:0] v;
    size    = 1 << f3[1:0];
    off     = int'(addr[2:0]);
    e.wr    = wr;
    e.maddr = addr & ~64'h7;
    e.be    = '0;
    e.wdata = '0;
    e.ld    = prev_ld;
    e.legal = !((f3 == 3'b111) || (wr && f3 >= 3'b100) || ((off % size) != 0));
    if (!e.legal) begin
      e.is_err   = 1'b1;
      e.done_cyc = 1;
      return e;
    end
    for (int i = 0; i < size; i++) begin
      e.be[off + i] = 1'b1;
      if (wr) e.wdata[8*(off + i) +: 8] = sdata[8*i +: 8];
    end
    if (delay >= TIMEOUT) begin
      e.is_err   = 1'b1;
      e.done_cyc = TIMEOUT + 1;
    end else begin
      e.is_err   = 1'b0;
      e.done_cyc = delay + 2;
      if (!wr) begin
        v = '0;
        for (int i = 0; i < size; i++) v[8*i +: 8] = rdata[8*(off + i) +: 8];
        if (f3 < 3'b011 && v[8*size - 1]) v = v | ~((64'd1 << (8*size)) - 64'd1);
        e.ld = v;
      end
    end
    return e;
  endfunction

  // ---------------- driver ----------------
  task automatic issue(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] sdata, input int delay, input logic [63:0] rdata);
    exp_t e;
    rsp_t r;
    int   n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      if (noise_en) begin
        START      = 1'($urandom_range(0, 1));
        WRITE      = 1'($urandom_range(0, 1));
        FUNCT3     = 3'($urandom_range(0, 7));
        ADDR       = {$urandom, $urandom};
        STORE_DATA = {$urandom, $urandom};
      end else begin
        START = 1'b0;
      end
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL busy_wait actual=busy required=idle within 200 cycles");
    end
    e = model(wr, f3, addr, sdata, delay, rdata, ld_model);
    e.start_cyc = cyc;
    e.done_cyc  = cyc + e.done_cyc;
    ld_model    = e.ld;
    exp_q.push_back(e);
    if (e.legal) begin
      r.delay = delay;
      r.rdata = rdata;
      rsp_q.push_back(r);
    end
    START      = 1'b1;
    WRITE      = wr;
    FUNCT3     = f3;
    ADDR       = addr;
    STORE_DATA = sdata;
    @(posedge CLK); #1;
    START = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      START = 1'b0;
      @(posedge CLK); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL drain actual=%0d pending required=0", exp_q.size());
    end
  endtask

  // ---------------- memory responder ----------------
  bit   in_req = 1'b0;
  int   rcnt = 0;
  rsp_t cur;

  always @(negedge CLK) begin
    if (MEM_REQ === 1'b1) begin
      if (!in_req) begin
        in_req = 1'b1;
        rcnt   = 0;
        if (rsp_q.size() > 0) cur = rsp_q.pop_front();
        else begin
          cur.delay = 1000;
          cur.rdata = '0;
        end
      end
      if (rcnt == cur.delay) begin
        MEM_ACK   = 1'b1;
        MEM_RDATA = cur.rdata;
      end else begin
        MEM_ACK   = 1'b0;
        MEM_RDATA = {$urandom, $urandom};
      end
      rcnt++;
    end else begin
      in_req    = 1'b0;
      MEM_ACK   = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
      MEM_RDATA = {$urandom, $urandom};
    end
  end

  // ---------------- monitor ----------------
  exp_t me;

  always @(negedge CLK) begin
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        me = exp_q[0];
        chk("busy", 64'(BUSY), 64'(cyc > me.start_cyc));
      end else begin
        chk("busy_idle", 64'(BUSY), 64'd0);
      end
      if (MEM_REQ === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_req actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          me = exp_q[0];
          chk("req_on_illegal", 64'(!me.legal), 64'd0);
          chk("mem_we", 64'(MEM_WE), 64'(me.wr));
          chk("mem_addr", MEM_ADDR, me.maddr);
          chk("mem_be", 64'(MEM_BE), 64'(me.be));
          if (me.wr) chk("mem_wdata", MEM_WDATA, me.wdata);
        end
      end
      if (DONE === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done actual=1 required=0 (cycle %0d)", cyc);
        end else begin
          me = exp_q.pop_front();
          chk("done_cycle", 64'(cyc), 64'(me.done_cyc));
          chk("err", 64'(ERR), 64'(me.is_err));
          chk("load_data", LOAD_DATA, me.ld);
        end
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].done_cyc) begin
        me = exp_q.pop_front();
        checks++; errors++;
        $display("FAIL done_missing actual=0 required=1 (cycle %0d)", cyc);
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [63:0] rd;

  initial begin
    // Reset state
    RESET_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_done", 64'(DONE), 64'd0);
    chk("rst_req", 64'(MEM_REQ), 64'd0);
    chk("rst_load", LOAD_DATA, 64'd0);
    RESET_N = 1'b1;
    @(posedge CLK); #1;
    mon_en = 1'b1;

    // Doubleword load, ACK two cycles after MEM_REQ
    issue(1'b0, 3'b011, 64'h10, 64'h0, 2, 64'h1122334455667788);
    // LB / LBU with byte 3 = 0x80
    rd = {$urandom, $urandom};
    rd[31:24] = 8'h80;
    issue(1'b0, 3'b000, 64'h13, 64'h0, 1, rd);
    issue(1'b0, 3'b100, 64'h13, 64'h0, 1, rd);
    // SH at offset 6, immediate ACK
    issue(1'b1, 3'b001, 64'h6, 64'hFFFF_ABCD, 0, 64'h0);
    // Misaligned LW and store with an unsigned FUNCT3
    issue(1'b0, 3'b010, 64'h2, 64'h0, 0, 64'h0);
    issue(1'b1, 3'b100, 64'h0, 64'h55, 0, 64'h0);
    issue(1'b0, 3'b111, 64'h8, 64'h0, 0, 64'h0);
    // Timeout with START noise during BUSY; ACK in the last allowed cycle
    noise_en = 1'b1;
    issue(1'b1, 3'b011, 64'h8, 64'hDEAD_BEEF_0123_4567, 100, 64'h0);
    issue(1'b1, 3'b011, 64'h18, 64'h0BAD_F00D_CAFE_0001, TIMEOUT - 1, 64'h0);
    issue(1'b0, 3'b010, 64'h24, 64'h0, TIMEOUT - 1, 64'hFEDC_BA98_8765_4321);
    issue(1'b0, 3'b001, 64'h2A, 64'h0, TIMEOUT, 64'h1234_5678_9ABC_DEF0);

    // Randomized traffic
    for (int t = 0; t < 200; t++) begin
      int          dly;
      logic [63:0] a;
      logic [2:0]  f;
      a = {$urandom, $urandom};
      f = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) begin
        a[2:0] = 3'(a[2:0] & ~((3'd1 << f[1:0]) - 3'd1));
      end
      dly = ($urandom_range(0, 9) == 0) ? $urandom_range(TIMEOUT - 2, TIMEOUT + 3)
                                        : $urandom_range(0, 4);
      issue(1'($urandom_range(0, 1)), f, a, {$urandom, $urandom}, dly,
            {$urandom, $urandom});
    end
    drain();

    // Reset in the middle of a request
    noise_en = 1'b0;
    issue(1'b0, 3'b011, 64'h40, 64'h0, 100, 64'h0);
    @(posedge CLK); #2;
    mon_en  = 1'b0;
    RESET_N = 1'b0;
    #1;
    chk("midrst_req", 64'(MEM_REQ), 64'd0);
    chk("midrst_busy", 64'(BUSY), 64'd0);
    chk("midrst_done", 64'(DONE), 64'd0);
    chk("midrst_err", 64'(ERR), 64'd0);
    chk("midrst_load", LOAD_DATA, 64'd0);
    chk("midrst_be", 64'(MEM_BE), 64'd0);
    exp_q.delete();
    rsp_q.delete();
    ld_model = '0;
    @(posedge CLK); #1;
    RESET_N = 1'b1;
    @(negedge CLK);
    chk("post_rst_busy", 64'(BUSY), 64'd0);
    @(posedge CLK); #1;
    mon_en = 1'b1;
    issue(1'b0, 3'b101, 64'h32, 64'h0, 1, 64'h0000_8001_0000_0000);
    drain();
    repeat (2) @(posedge CLK);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
